entrada_aposta: RTL and testbench
=================================

ENTRADA_APOSTA -- requirements
Module: entrada_aposta

Interface
REQ-001 SHALL have parameter N_NUM, default 5: numbers per bet, legal range 2..7.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tecla  input  4  keyed number 0..15.
REQ-005 SHALL have port tecla_valida  input  1  one-cycle strobe qualifying tecla.
REQ-006 SHALL have port confirma  input  1  request to send the collected bet.
REQ-007 SHALL have port cancela  input  1  discard the collected numbers.
REQ-008 SHALL have port encerra  input  1  end the session.
REQ-009 SHALL have port numero  output  4  number presented to the downstream Loteria stage.
REQ-010 SHALL have port insere  output  1  high while numero carries a valid bet number.
REQ-011 SHALL have port fim  output  1  one-cycle end-of-bet pulse.
REQ-012 SHALL have port fim_jogo  output  1  session ended; held high.
REQ-013 SHALL have port qtd  output  3  count of numbers currently collected.
REQ-014 SHALL have port erro  output  1  one-cycle rejected-input pulse.
REQ-015 SHALL have port ocupado  output  1  high while sending; keypad inputs ignored.
REQ-016 SHALL have port jogos  output  4  bets sent since reset, saturating at 15.

Function
REQ-017 SHALL implement states COLETA, ENVIA, FIM, ENCERRADO, with every output registered.
REQ-018 COLETA, tecla_valida: if qtd==N_NUM or tecla equals a stored number, erro SHALL pulse next cycle with buffer unchanged; else tecla SHALL be stored at index qtd and qtd incremented.
REQ-019 COLETA input priority SHALL be cancela > encerra > confirma > tecla_valida; lower-priority inputs in the same cycle are ignored without erro.
REQ-020 COLETA, cancela: qtd SHALL clear to 0 next cycle, with no erro.
REQ-021 COLETA, confirma with qtd==N_NUM: SHALL enter ENVIA with index 0.
REQ-022 COLETA, confirma with qtd<N_NUM: SHALL pulse erro and stay in COLETA.
REQ-023 Confirma sampled at edge k: insere SHALL be high for cycles k+1..k+N_NUM, with numero = buf[0..N_NUM-1] in entry order.
REQ-024 After ENVIA: fim SHALL be high during cycle k+N_NUM+1 only (FIM state); qtd SHALL clear; jogos SHALL increment unless already 15.
REQ-025 After FIM: the block SHALL return to COLETA and accept input from edge k+N_NUM+2.
REQ-026 ocupado SHALL be high during cycles k+1..k+N_NUM+1.
REQ-027 While ocupado, tecla_valida/confirma/cancela/encerra SHALL be ignored, with no erro.
REQ-028 numero SHALL hold its last value when insere is low; it is 0 after reset.
REQ-029 COLETA, encerra with qtd==0: SHALL enter ENCERRADO and set fim_jogo next cycle.
REQ-030 COLETA, encerra with qtd>0: SHALL pulse erro and stay in COLETA.
REQ-031 ENCERRADO: fim_jogo SHALL stay high, all inputs ignored, no erro; exit only by reset.
REQ-032 insere and fim SHALL never be high in the same cycle.
REQ-033 erro and insere SHALL never be high in the same cycle.

Reset
REQ-034 reset high SHALL immediately (asynchronously) force COLETA and clear the buffer.
REQ-035 During reset, numero/insere/fim/fim_jogo/qtd/erro/ocupado/jogos SHALL all be 0.
REQ-036 Reset asserted mid-ENVIA SHALL abort the transfer; no fim follows and jogos is not incremented.
REQ-037 The first edge after reset deasserts SHALL already be able to accept tecla_valida.

Verification
REQ-038 Nominal bet: keys 5,3,8,1,0 then confirma -> qtd=5; insere high 5 cycles with numero 5,3,8,1,0; one-cycle fim; qtd=0; jogos=1.
REQ-039 Duplicate key: keys 5,3,5 -> erro pulses on the third key; qtd=2. Overflow: a 6th distinct key (qtd=5) -> erro, qtd stays 5.
REQ-040 Early confirma with qtd=3 -> erro pulse, no insere; cancela + tecla_valida(7) same cycle -> qtd=0, 7 not stored, no erro.
REQ-041 Keys pressed during ocupado -> ignored, no erro, qtd=0 after fim; the next bet is sent correctly.
REQ-042 encerra with qtd=2 -> erro; cancela then encerra -> fim_jogo=1 held; later keys/confirma -> no change.
REQ-043 Reset pulse during the 3rd insere cycle -> all outputs 0 immediately; no fim; jogos=0. 16 completed bets -> jogos saturates at 15.

Source files
------------

// File: rtl/entrada_aposta.sv
// entrada_aposta: keypad bet collector that streams N_NUM distinct numbers to the Loteria stage.
// Revision 1.0 -- initial release.
`default_nettype none

module entrada_aposta #(
  parameter int N_NUM = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] tecla,
  input  logic       tecla_valida,
  input  logic       confirma,
  input  logic       cancela,
  input  logic       encerra,
  output logic [3:0] numero,
  output logic       insere,
  output logic       fim,
  output logic       fim_jogo,
  output logic [2:0] qtd,
  output logic       erro,
  output logic       ocupado,
  output logic [3:0] jogos
);

  localparam logic [2:0] NQ = 3'(N_NUM);

  typedef enum logic [1:0] {
    COLETA    = 2'd0,
    ENVIA     = 2'd1,
    FIM       = 2'd2,
    ENCERRADO = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [3:0] nums   [N_NUM];
  logic [3:0] nums_n [N_NUM];
  logic [2:0] idx, idx_n;
  logic [3:0] numero_n, jogos_n;
  logic [2:0] qtd_n;
  logic       insere_n, fim_n, fim_jogo_n, erro_n, ocupado_n;
  logic       dup;

  // A key is a duplicate only if it matches one of the slots already filled.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < N_NUM; i++) begin
      if ((3'(i) < qtd) && (nums[i] == tecla)) dup = 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    nums_n     = nums;
    idx_n      = idx;
    numero_n   = numero;
    qtd_n      = qtd;
    jogos_n    = jogos;
    fim_jogo_n = fim_jogo;
    ocupado_n  = ocupado;
    insere_n   = 1'b0;
    fim_n      = 1'b0;
    erro_n     = 1'b0;

    case (state)
      COLETA: begin
        if (cancela) begin
          qtd_n = 3'd0;
        end else if (encerra) begin
          if (qtd == 3'd0) begin
            state_n    = ENCERRADO;
            fim_jogo_n = 1'b1;
          end else begin
            erro_n = 1'b1;
          end
        end else if (confirma) begin
          if (qtd == NQ) begin
            // First number goes out on the same edge that accepts confirma.
            state_n   = ENVIA;
            numero_n  = nums[0];
            insere_n  = 1'b1;
            ocupado_n = 1'b1;
            idx_n     = 3'd1;
          end else begin
            erro_n = 1'b1;
          end
        end else if (tecla_valida) begin
          if ((qtd == NQ) || dup) begin
            erro_n = 1'b1;
          end else begin
            nums_n[qtd] = tecla;
            qtd_n       = qtd + 3'd1;
          end
        end
      end

      ENVIA: begin
        if (idx == NQ) begin
          state_n = FIM;
          fim_n   = 1'b1;
          qtd_n   = 3'd0;
          if (jogos != 4'd15) jogos_n = jogos + 4'd1;
        end else begin
          numero_n = nums[idx];
          insere_n = 1'b1;
          idx_n    = idx + 3'd1;
        end
      end

      FIM: begin
        state_n   = COLETA;
        ocupado_n = 1'b0;
      end

      default: begin
        state_n = ENCERRADO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= COLETA;
      idx      <= 3'd0;
      numero   <= 4'd0;
      insere   <= 1'b0;
      fim      <= 1'b0;
      fim_jogo <= 1'b0;
      qtd      <= 3'd0;
      erro     <= 1'b0;
      ocupado  <= 1'b0;
      jogos    <= 4'd0;
      for (int i = 0; i < N_NUM; i++) nums[i] <= 4'd0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      numero   <= numero_n;
      insere   <= insere_n;
      fim      <= fim_n;
      fim_jogo <= fim_jogo_n;
      qtd      <= qtd_n;
      erro     <= erro_n;
      ocupado  <= ocupado_n;
      jogos    <= jogos_n;
      for (int i = 0; i < N_NUM; i++) nums[i] <= nums_n[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_entrada_aposta.sv
// tb_entrada_aposta: directed and randomized checks of entrada_aposta against a queue-based bet model.
// Revision 1.0 -- initial release.
`default_nettype none

module tb_entrada_aposta;

  localparam int N = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] tecla = 4'd0;
  logic       tecla_valida = 1'b0;
  logic       confirma = 1'b0;
  logic       cancela = 1'b0;
  logic       encerra = 1'b0;
  logic [3:0] numero;
  logic       insere;
  logic       fim;
  logic       fim_jogo;
  logic [2:0] qtd;
  logic       erro;
  logic       ocupado;
  logic [3:0] jogos;

  entrada_aposta #(.N_NUM(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .tecla        (tecla),
    .tecla_valida (tecla_valida),
    .confirma     (confirma),
    .cancela      (cancela),
    .encerra      (encerra),
    .numero       (numero),
    .insere       (insere),
    .fim          (fim),
    .fim_jogo     (fim_jogo),
    .qtd          (qtd),
    .erro         (erro),
    .ocupado      (ocupado),
    .jogos        (jogos)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the bet is a queue of numbers; a send is a scripted
  // sequence of N number cycles, one end cycle and one recovery cycle.
  int         mq[$];
  int         sq[$];
  int         jog;
  bit         ended;
  bit         sending;
  int         pos;
  logic [3:0] e_numero;
  bit         e_insere, e_fim, e_erro, e_ocup;

  task automatic model_reset();
    mq.delete();
    sq.delete();
    jog      = 0;
    ended    = 1'b0;
    sending  = 1'b0;
    pos      = 0;
    e_numero = 4'd0;
    e_insere = 1'b0;
    e_fim    = 1'b0;
    e_erro   = 1'b0;
    e_ocup   = 1'b0;
  endtask

  task automatic model_edge(input bit tv, input int t, input bit cf, input bit cn, input bit en);
    bit dup;
    dup      = 1'b0;
    e_insere = 1'b0;
    e_fim    = 1'b0;
    e_erro   = 1'b0;
    if (sending) begin
      pos++;
      if (pos < N) begin
        e_insere = 1'b1;
        e_numero = 4'(sq[pos]);
      end else if (pos == N) begin
        e_fim = 1'b1;
        mq.delete();
        if (jog < 15) jog++;
      end else begin
        sending = 1'b0;
        e_ocup  = 1'b0;
      end
    end else if (ended) begin
      // session over: nothing changes until reset
    end else if (cn) begin
      mq.delete();
    end else if (en) begin
      if (mq.size() == 0) ended = 1'b1;
      else e_erro = 1'b1;
    end else if (cf) begin
      if (mq.size() == N) begin
        sending  = 1'b1;
        pos      = 0;
        sq       = mq;
        e_insere = 1'b1;
        e_numero = 4'(sq[0]);
        e_ocup   = 1'b1;
      end else begin
        e_erro = 1'b1;
      end
    end else if (tv) begin
      foreach (mq[i]) if (mq[i] == t) dup = 1'b1;
      if (dup || mq.size() == N) e_erro = 1'b1;
      else mq.push_back(t);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".numero"},   numero,            e_numero);
    chk({tag, ".insere"},   {3'd0, insere},    {3'd0, e_insere});
    chk({tag, ".fim"},      {3'd0, fim},       {3'd0, e_fim});
    chk({tag, ".fim_jogo"}, {3'd0, fim_jogo},  {3'd0, ended});
    chk({tag, ".qtd"},      {1'b0, qtd},       4'(mq.size()));
    chk({tag, ".erro"},     {3'd0, erro},      {3'd0, e_erro});
    chk({tag, ".ocupado"},  {3'd0, ocupado},   {3'd0, e_ocup});
    chk({tag, ".jogos"},    jogos,             4'(jog));
  endtask

  task automatic step(input string tag, input bit tv, input int t, input bit cf, input bit cn, input bit en);
    tecla_valida = tv;
    tecla        = 4'(t);
    confirma     = cf;
    cancela      = cn;
    encerra      = en;
    @(posedge clock);
    model_edge(tv, t, cf, cn, en);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input string tag, input int t);
    step(tag, 1'b1, t, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset is applied mid-cycle so its asynchronous effect is observed before any edge.
  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    #12;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    // nominal bet, first key on the first edge after reset
    key("nom", 5); key("nom", 3); key("nom", 8); key("nom", 1); key("nom", 0);
    step("nom.cf", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle("nom.send", N + 2);
    chk("nom.jogos_one", jogos, 4'd1);

    // duplicate and overflow
    key("dup", 5); key("dup", 3); key("dup", 5);
    key("ovf", 8); key("ovf", 1); key("ovf", 0); key("ovf", 9);
    step("ovf.cn", 1'b0, 0, 1'b0, 1'b1, 1'b0);

    // early confirma, then cancela together with a key
    key("early", 2); key("early", 4); key("early", 6);
    step("early.cf", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step("cn_tv", 1'b1, 7, 1'b0, 1'b1, 1'b0);
    idle("cn_tv.idle", 1);

    // keys and commands while sending are ignored
    key("busy", 1); key("busy", 2); key("busy", 3); key("busy", 4); key("busy", 5);
    step("busy.cf", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step("busy.k", 1'b1, 9, 1'b0, 1'b0, 1'b0);
    step("busy.cf2", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step("busy.cn", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    step("busy.en", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N - 1; i++) step("busy.k2", 1'b1, 10 + i, 1'b0, 1'b0, 1'b0);
    key("next", 15); key("next", 14); key("next", 13); key("next", 12); key("next", 11);
    step("next.cf", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle("next.send", N + 2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (ended) do_reset("rnd.rst");
      step("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 9)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
    end
    do_reset("rst2");

    // reset in the third insere cycle aborts the bet
    key("abort", 1); key("abort", 2); key("abort", 3); key("abort", 4); key("abort", 5);
    step("abort.cf", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    step("abort.s2", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step("abort.s3", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("abort.third", numero, 4'd3);
    do_reset("abort.rst");
    idle("abort.after", N + 2);

    // encerra with numbers held, then a clean end of session
    key("enc", 4); key("enc", 6);
    step("enc.err", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step("enc.cn", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    step("enc.ok", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    key("enc.k", 3);
    step("enc.cf", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle("enc.hold", 3);
    chk("enc.fim_jogo", {3'd0, fim_jogo}, 4'd1);

    // sixteen bets saturate the counter
    do_reset("sat.rst");
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < N; k++) key("sat.k", (b + k) % 16);
      step("sat.cf", 1'b0, 0, 1'b1, 1'b0, 1'b0);
      idle("sat.send", N + 1);
    end
    chk("sat.jogos15", jogos, 4'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
